// File: rtl/axis_to_vga.sv
// axis_to_vga: AXI-Stream pixel sink driving registered VGA timing with SOF/EOF frame alignment.
module axis_to_vga #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [31:0] in_stream_tdata,
  input  logic [3:0]  in_stream_tkeep,
  input  logic        in_stream_tlast,
  input  logic        in_stream_tuser,
  input  logic        in_stream_tvalid,
  output logic        in_stream_tready,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_de,
  output logic        underflow,
  output logic        frame_err
);
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [HW-1:0] H_END = HW'(HT - 1);
  localparam logic [HW-1:0] H_ACT = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LPX = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_B  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_E  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_END = VW'(VT - 1);
  localparam logic [VW-1:0] V_ACT = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_LPX = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VS_B  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_E  = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {SEEK, ALIGN, RUN} state_t;
  state_t state, state_n;

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [25:0]   mem [FIFO_DEPTH];
  logic [AW:0]   wptr, rptr;
  logic [25:0]   head;
  logic active, origin, last_px, run_px, empty, full, xfer, wr, pop, uf, err, flush;
  logic unused;

  assign unused  = ^{in_stream_tkeep, in_stream_tdata[7:0]};
  assign head    = mem[rptr[AW-1:0]];
  assign empty   = wptr == rptr;
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign active  = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign origin  = (hcnt == '0) && (vcnt == '0);
  assign last_px = (hcnt == H_LPX) && (vcnt == V_LPX);
  assign in_stream_tready = !areset && (state == SEEK || !full);
  assign xfer    = in_stream_tvalid && in_stream_tready;
  // The ALIGN cycle at the frame origin displays the SOF word, so it counts as a pixel slot.
  assign run_px  = (state == RUN && active) || (state == ALIGN && origin);
  assign pop     = run_px && !empty;
  assign uf      = run_px && empty;
  assign err     = pop && (head[1] != origin || head[0] != last_px);
  assign flush   = uf || err;
  assign wr      = xfer && (state != SEEK || in_stream_tuser) && !flush;

  always_comb begin
    state_n = state;
    if (flush) state_n = SEEK;
    else if (state == SEEK && wr) state_n = ALIGN;
    else if (state == ALIGN && origin) state_n = RUN;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state     <= SEEK;
      hcnt      <= '0;
      vcnt      <= '0;
      wptr      <= '0;
      rptr      <= '0;
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
      vga_de    <= 1'b0;
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
      underflow <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_n;
      hcnt  <= (hcnt == H_END) ? '0 : hcnt + 1'b1;
      if (hcnt == H_END) vcnt <= (vcnt == V_END) ? '0 : vcnt + 1'b1;
      wptr  <= flush ? '0 : wptr + {{AW{1'b0}}, wr};
      rptr  <= flush ? '0 : rptr + {{AW{1'b0}}, pop};
      {vga_r, vga_g, vga_b} <= pop ? head[25:2] : 24'd0;
      vga_de    <= run_px;
      vga_hsync <= !(hcnt >= HS_B && hcnt < HS_E);
      vga_vsync <= !(vcnt >= VS_B && vcnt < VS_E);
      underflow <= underflow || uf;
      frame_err <= err;
    end
  end

  always_ff @(posedge aclk) begin
    if (wr) mem[wptr[AW-1:0]] <= {in_stream_tdata[31:8], in_stream_tuser, in_stream_tlast};
  end
endmodule

// File: tb/tb_axis_to_vga.sv
// tb_axis_to_vga: random-colour frame stream against a frame-level display model with a pixel scoreboard.
module tb_axis_to_vga;
  localparam int HA = 16, HF = 2, HS = 4, HB = 2;
  localparam int VA = 8, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int NP = HA * VA;
  localparam int NF = 12;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic tlast, tuser, tvalid, tready;
  logic [7:0] vr, vg, vb;
  logic hs, vs, de, ufl, fe;

  always #5 aclk = ~aclk;

  axis_to_vga #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .FIFO_DEPTH(8)
  ) dut (
    .aclk(aclk), .areset(areset),
    .in_stream_tdata(tdata), .in_stream_tkeep(tkeep), .in_stream_tlast(tlast),
    .in_stream_tuser(tuser), .in_stream_tvalid(tvalid), .in_stream_tready(tready),
    .vga_r(vr), .vga_g(vg), .vga_b(vb), .vga_hsync(hs), .vga_vsync(vs), .vga_de(de),
    .underflow(ufl), .frame_err(fe)
  );

  typedef struct {int d; int x; int y; logic [23:0] rgb;} exp_t;
  exp_t q[$];

  int tests = 0, fails = 0;
  int mc = 0, epoch = 0;
  int fe_cnt = 0, fe_mc = -1, uf_mc = -1;
  int hs_lo = 0, vs_lo = 0, de_hi = 0;
  bit start = 0, driver_done = 0;
  logic [23:0] pix [NF][NP];
  // Display frame each source frame lands in (counted from the latest reset) and how many of its pixels show.
  int dframe [NF] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 1, 2};
  int ndisp  [NF] = '{NP, NP, NP, NP, 53, NP, 112, NP, NP, 89, NP, NP};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic send(input logic [23:0] c, input logic u, input logic l);
    bit ok = 0;
    int n = 0;
    tvalid = 1'b1;
    tdata  = {c, 8'($urandom)};
    tkeep  = 4'($urandom);
    tuser  = u;
    tlast  = l;
    while (!ok && n < 3000) begin
      #8;
      ok = tready;
      @(posedge aclk);
      #1;
      n++;
    end
    tvalid = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: tready stayed low for %0d cycles", n);
    end
  endtask

  initial forever begin
    @(posedge aclk);
    mc = areset ? 0 : mc + 1;
  end

  initial begin
    int p, d, x, y;
    exp_t e;
    forever begin
      @(negedge aclk);
      if (!areset && mc > 0) begin
        p = (mc - 1) % FT;
        d = (mc - 1) / FT;
        x = p % HT;
        y = p / HT;
        chk("hsync", hs, !(x >= HA + HF && x < HA + HF + HS));
        chk("vsync", vs, !(y >= VA + VF && y < VA + VF + VS));
        if (de) begin
          if (q.size() == 0) chk("extra_de", de, 0);
          else begin
            e = q.pop_front();
            chk("pix_frame", d, e.d);
            chk("pix_x", x, e.x);
            chk("pix_y", y, e.y);
            chk("pix_rgb", {vr, vg, vb}, e.rgb);
          end
        end else chk("blank_rgb", {vr, vg, vb}, 0);
        if (fe) begin
          fe_cnt++;
          fe_mc = mc;
        end
        if (ufl && uf_mc < 0) uf_mc = mc;
        if (epoch == 0 && (d == 8 || d == 9)) begin
          hs_lo += int'(!hs);
          vs_lo += int'(!vs);
          de_hi += int'(de);
        end
      end
    end
  end

  initial begin
    wait (start);
    @(posedge aclk);
    #1;
    repeat (3) send(24'($urandom), 1'b0, 1'b0);
    for (int f = 0; f < NF; f++) begin
      for (int i = 0; i < NP; i++) begin
        if (f == 4 && i == 53) begin
          repeat (40) @(posedge aclk);
          #1;
        end
        if (i == 0) begin
          for (int k = 0; k < ndisp[f]; k++) q.push_back('{dframe[f], k % HA, k / HA, pix[f][k]});
          if (f == 4) q.push_back('{5, 53 % HA, 53 / HA, 24'd0});
        end
        send(pix[f][i], i == 0, i == NP - 1 || (f == 6 && i == 111));
      end
    end
    driver_done = 1;
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rgb"}, {vr, vg, vb}, 0);
    chk({tag, "_de"}, de, 0);
    chk({tag, "_hsync"}, hs, 1);
    chk({tag, "_vsync"}, vs, 1);
    chk({tag, "_underflow"}, ufl, 0);
    chk({tag, "_frame_err"}, fe, 0);
    chk({tag, "_tready"}, tready, 0);
  endtask

  initial begin
    int n;
    tvalid = 0; tdata = 0; tkeep = 0; tuser = 0; tlast = 0;
    for (int f = 0; f < NF; f++)
      for (int i = 0; i < NP; i++) pix[f][i] = 24'($urandom);
    repeat (3) @(posedge aclk);
    #2;
    chk_reset_outputs("por");
    #5 areset = 1'b0;
    #1 chk("tready_after_release", tready, 1);
    start = 1;
    // Mid-frame reset right after pixel (8,5) of display frame 10 has been sampled.
    while (mc < 10 * FT + 5 * HT + 8 + 1) @(negedge aclk);
    chk("underflow_sticky", ufl, 1);
    chk("underflow_cycle", uf_mc, 5 * FT + 3 * HT + 5 + 1);
    chk("frame_err_count", fe_cnt, 1);
    chk("frame_err_cycle", fe_mc, 7 * FT + 6 * HT + 15 + 1);
    chk("hsync_low_2frames", hs_lo, 2 * VT * HS);
    chk("vsync_low_2frames", vs_lo, 2 * VS * HT);
    chk("de_high_2frames", de_hi, 2 * NP);
    #2 areset = 1'b1;
    epoch = 1;
    #1 chk_reset_outputs("async");
    repeat (2) @(posedge aclk);
    #7 areset = 1'b0;
    #1 chk("tready_after_rerelease", tready, 1);
    n = 0;
    while ((!driver_done || q.size() != 0) && n < 5000) begin
      @(negedge aclk);
      n++;
    end
    chk("driver_done", driver_done, 1);
    chk("queue_drained", q.size(), 0);
    chk("underflow_after_resync", ufl, 0);
    chk("frame_err_total", fe_cnt, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axis_to_vga.md
AXIS_TO_VGA -- requirements
Module: axis_to_vga

Interface
REQ-001 Parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 Parameter H_FP/H_SYNC/H_BP, default 16/96/48, horizontal porch/sync widths in clocks; line total 800.
REQ-003 Parameter V_ACTIVE, default 480, active lines per frame.
REQ-004 Parameter V_FP/V_SYNC/V_BP, default 10/2/33, vertical porch/sync widths in lines; frame total 525.
REQ-005 Parameter FIFO_DEPTH, default 16, pixel FIFO entries, power of two.
REQ-006 aclk  input  1  single clock; all logic on rising edge.
REQ-007 areset  input  1  asynchronous, active-high reset.
REQ-008 in_stream_tdata  input  32  pixel: [31:24] R, [23:16] G, [15:8] B, [7:0] ignored.
REQ-009 in_stream_tkeep  input  4  ignored.
REQ-010 in_stream_tlast  input  1  last pixel of frame.
REQ-011 in_stream_tuser  input  1  first pixel of frame (SOF).
REQ-012 in_stream_tvalid  input  1  upstream word valid.
REQ-013 in_stream_tready  output  1  block accepts word this cycle.
REQ-014 vga_r, vga_g, vga_b  output  8 each  pixel colour; 0 outside active area.
REQ-015 vga_hsync, vga_vsync  output  1 each  sync, active-low.
REQ-016 vga_de  output  1  display enable, high in active area.
REQ-017 underflow  output  1  sticky: FIFO empty when a pixel was required.
REQ-018 frame_err  output  1  one-cycle pulse on SOF/EOF misalignment.

Function
REQ-019 Word transfer = tvalid & tready same cycle; unaccepted words are not consumed.
REQ-020 Timing counters hcnt (0..799), vcnt (0..524) free-run from reset; hcnt wraps 799->0, incrementing vcnt; vcnt wraps 524->0.
REQ-021 Active area: hcnt<640 and vcnt<480; hsync low for hcnt 656..751; vsync low for vcnt 490..491.
REQ-022 FIFO stores {R,G,B,tuser,tlast} (26 bits); write on transfer; read on pop; simultaneous read and write at full or empty both honoured when legal (no write at full, no pop at empty).
REQ-023 States: SEEK, ALIGN, RUN.
REQ-024 SEEK: tready=1; words with tuser=0 discarded; a word with tuser=1 is written to FIFO -> ALIGN.
REQ-025 ALIGN/RUN: tready = FIFO not full; outputs black, de low in ALIGN.
REQ-026 ALIGN -> RUN on the cycle hcnt=0 and vcnt=0; that cycle pops the SOF word.
REQ-027 RUN: one pop per active-area cycle; no pop outside active area.
REQ-028 Outputs registered: all vga_* outputs lag hcnt/vcnt by exactly 1 clock, colour/de/syncs mutually aligned.
REQ-029 RUN, active cycle, FIFO empty: output black with de high, underflow<=1, flush FIFO, -> SEEK.
REQ-030 RUN, popped word has tuser=1 at position other than (0,0), or tuser=0 at (0,0): frame_err pulse, flush, -> SEEK.
REQ-031 RUN, popped word at (639,479) has tlast=0, or tlast=1 elsewhere: frame_err pulse, flush, -> SEEK.
REQ-032 On any flush, the word written in the same cycle is dropped; timing counters keep running.
REQ-033 underflow clears only on reset.

Reset
REQ-034 areset asserted: state SEEK, hcnt=vcnt=0, FIFO empty, tready=0 while asserted, vga_r/g/b=0, vga_de=0, vga_hsync=vga_vsync=1, underflow=0, frame_err=0.
REQ-035 Reset mid-frame aborts immediately; first clock after release resumes from SEEK with tready=1.

Verification
REQ-036 Continuous valid 640x480 stream with SOF/EOF after reset -> one frame skipped in ALIGN, then pixel (x,y) appears at output cycle (y*800+x+1) after frame start; underflow=0, no frame_err.
REQ-037 3 words tuser=0 then SOF -> 3 words discarded, SOF pixel is first displayed pixel at (0,0).
REQ-038 Upstream stalls tvalid=0 for 40 cycles mid-line in RUN -> underflow=1, black output, return to SEEK, next SOF restores correct frame.
REQ-039 Stream with tlast at pixel 639 of line 478 -> frame_err pulse 1 cycle, FIFO flushed, state SEEK.
REQ-040 Timing check over 2 frames: hsync low 96 clocks every 800, vsync low 1600 clocks every 420000, de high 640 clocks per active line.
REQ-041 areset pulsed during line 200 -> all outputs at reset values asynchronously, clean resync on next SOF.
